// File: rtl/bitswap_checker_pkg.sv
// bitswap_checker_pkg: shared FSM state type and counter width for the bit-swap checker
package bitswap_checker_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bitswap_checker_vec.sv
// vec_delay: fixed-latency vector delay line with synchronous clear
module vec_delay
    import bitswap_checker_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [LATENCY];

    // shift every cycle regardless of checker state so data is always aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[LATENCY-1];

endmodule

// File: rtl/bitswap_checker.sv
// bitswap_checker: compares a stage's output against the delayed bit-reversal of its input
module bitswap_checker
    import bitswap_checker_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int LATENCY     = 1,
    parameter int NUM_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] invec,
    input  logic [WIDTH-1:0] outvec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_err, r_smp, w_err_nx, w_smp_nx;
    logic [3:0]       r_prime, w_prime_nx;
    logic [WIDTH-1:0] w_rev, w_exp;

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign w_rev[g] = invec[WIDTH-1-g];
    end

    vec_delay #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_delay (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_rev),
        .o_q   (w_exp)
    );

    // state and counter registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_err   <= '0;
            r_smp   <= '0;
            r_prime <= '0;
        end else begin
            r_state <= w_state_nx;
            r_err   <= w_err_nx;
            r_smp   <= w_smp_nx;
            r_prime <= w_prime_nx;
        end
    end

    // next state: prime for LATENCY cycles, then compare NUM_SAMPLES vectors
    always_comb begin
        w_state_nx = r_state;
        w_err_nx   = r_err;
        w_smp_nx   = r_smp;
        w_prime_nx = r_prime;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nx = PRIME;
                    w_err_nx   = '0;
                    w_smp_nx   = '0;
                    w_prime_nx = '0;
                end
            end
            PRIME: begin
                w_prime_nx = r_prime + 4'd1;
                w_state_nx = (r_prime == 4'(LATENCY-1)) ? CHECK : PRIME;
            end
            CHECK: begin
                w_smp_nx   = r_smp + 8'd1;
                w_err_nx   = (outvec != w_exp && r_err != '1) ? r_err + 8'd1 : r_err;
                w_state_nx = (r_smp == CNT_W'(NUM_SAMPLES-1)) ? DONE : CHECK;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign busy         = (r_state == PRIME) || (r_state == CHECK);
    assign done         = (r_state == DONE);
    assign pass         = done && (r_err == '0);
    assign err_count    = r_err;
    assign sample_count = r_smp;

endmodule

// File: tb/tb_bitswap_checker.sv
// tb_bitswap_checker: directed and randomized checks of bitswap_checker against a run-level model
module tb_bitswap_checker;

    logic       clk;
    logic       rst0, start0, busy0, done0, pass0;
    logic [1:0] in0, out0, st0;
    logic [7:0] err0, smp0;
    logic       mode0;

    logic       rst1, start1, busy1, done1, pass1;
    logic [3:0] in1, out1, fmask;
    logic [3:0] st1 [3];
    logic [7:0] err1, smp1;
    logic       sat;

    int nvec, nfail, fpct, win, mexp;

    bitswap_checker dut0 (
        .clk(clk), .reset(rst0), .start(start0), .invec(in0), .outvec(out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .sample_count(smp0)
    );

    bitswap_checker #(.WIDTH(4), .LATENCY(3), .NUM_SAMPLES(255)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .invec(in1), .outvec(out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .sample_count(smp1)
    );

    function automatic logic [1:0] rev2(input logic [1:0] v);
        return {v[0], v[1]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    initial clk = 0;
    always #5 clk = ~clk;

    // stages under check: dut0 sees a 1-cycle swap or pass-through, dut1 a 3-cycle swap with faults
    always @(posedge clk) begin
        st0    <= mode0 ? in0 : rev2(in0);
        st1[0] <= rev4(in1) ^ (sat ? 4'hF : fmask);
        st1[1] <= st1[0];
        st1[2] <= st1[1];
    end
    assign out0 = st0;
    assign out1 = st1[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        in0   = in0 + 2'd1;
        in1   = 4'($urandom);
        fmask = ($urandom_range(0, 99) < fpct) ? 4'($urandom_range(1, 15)) : 4'd0;
        if (win > 0) begin
            if (fmask != 0) mexp++;
            win--;
        end
    endtask

    task automatic wait_done0(input string tag);
        int n = 0;
        while (!done0 && n < 50) begin step(); n++; end
        chk(tag, done0, 1);
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (!done1 && n < 400) begin step(); n++; end
        chk(tag, done1, 1);
    endtask

    initial begin
        int n;
        logic seen;
        nvec = 0; nfail = 0; fpct = 0; win = 0; mexp = 0;
        rst0 = 1; rst1 = 1; start0 = 0; start1 = 0;
        in0 = 0; in1 = 0; fmask = 0; mode0 = 0; sat = 0;
        step(); step();
        chk("rst_busy0", busy0, 0); chk("rst_smp0", smp0, 0);
        rst0 = 0; rst1 = 0;
        step();
        chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);   chk("rst_smp", smp0, 0);
        chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0); chk("rst_err1", err1, 0);

        // correct swap, single start pulse
        start0 = 1;
        step();
        start0 = 0;
        n = 0;
        while (busy0 && n < 20) begin n++; step(); end
        chk("swap_busy_len", n, 5);
        chk("swap_done", done0, 1); chk("swap_pass", pass0, 1);
        chk("swap_smp", smp0, 4);   chk("swap_err", err0, 0);
        step(); step(); step();
        chk("swap_hold_done", done0, 1); chk("swap_hold_smp", smp0, 4);

        // pass-through stage: values 1 and 2 mismatch once each
        mode0 = 1;
        step();
        start0 = 1;
        step();
        start0 = 0;
        chk("fault_busy", busy0, 1); chk("fault_clr_smp", smp0, 0);
        wait_done0("fault_wait");
        chk("fault_pass", pass0, 0); chk("fault_err", err0, 2); chk("fault_smp", smp0, 4);

        // start held through the run, restart only from DONE
        mode0 = 0;
        start0 = 1;
        step();
        wait_done0("hold_wait");
        chk("hold_smp", smp0, 4); chk("hold_pass", pass0, 1);
        step();
        chk("hold_restart_busy", busy0, 1); chk("hold_restart_done", done0, 0);
        chk("hold_restart_smp", smp0, 0);   chk("hold_restart_err", err0, 0);
        start0 = 0;
        wait_done0("hold_wait2");
        chk("hold2_smp", smp0, 4); chk("hold2_pass", pass0, 1);

        // reset in the middle of CHECK
        step();
        start0 = 1;
        step();
        start0 = 0;
        n = 0;
        while (smp0 != 2 && n < 20) begin step(); n++; end
        chk("mid_reach2", smp0, 2); chk("mid_busy_before", busy0, 1);
        rst0 = 1;
        step();
        rst0 = 0;
        chk("mid_busy", busy0, 0); chk("mid_done", done0, 0);
        chk("mid_smp", smp0, 0);   chk("mid_err", err0, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin step(); seen |= done0; end
        chk("mid_no_done", seen, 0);

        // always-wrong stage saturates the error counter
        sat = 1;
        step();
        start1 = 1;
        step();
        start1 = 0;
        wait_done1("sat_wait");
        chk("sat_err", err1, 255); chk("sat_smp", smp1, 255); chk("sat_pass", pass1, 0);
        step(); step();
        chk("sat_hold_err", err1, 255); chk("sat_hold_smp", smp1, 255);
        sat = 0;

        // random faults: mismatches equal faulty inputs among the compared window
        for (int r = 0; r < 3; r++) begin
            fpct = (r == 0) ? 20 : (r == 1) ? 2 : 0;
            step();
            start1 = 1;
            mexp = 0;
            win = 255;
            step();
            start1 = 0;
            wait_done1("rnd_wait");
            chk("rnd_err", err1, mexp);
            chk("rnd_smp", smp1, 255);
            chk("rnd_pass", pass1, (mexp == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/bitswap_checker.md
BITSWAP_CHECKER -- requirements
Module: bitswap_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 2, giving the vector width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter LATENCY, default 1, giving the cycles from invec to outvec of the stage under check (legal range 1..8).
REQ-003 The module SHALL have parameter NUM_SAMPLES, default 4, giving the compares per run (legal range 1..255).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit, a run request pulse.
REQ-007 The module SHALL have port invec, input, WIDTH bits, the stimulus driven into the stage under check.
REQ-008 The module SHALL have port outvec, input, WIDTH bits, the output of the stage under check.
REQ-009 The module SHALL have port busy, output, 1 bit, high in PRIME or CHECK.
REQ-010 The module SHALL have port done, output, 1 bit, high in DONE.
REQ-011 The module SHALL have port pass, output, 1 bit, equal to done AND (err_count == 0).
REQ-012 The module SHALL have port err_count, output, 8 bits, the mismatches in the current or last run.
REQ-013 The module SHALL have port sample_count, output, 8 bits, the compares performed in the current or last run.

Function
REQ-014 The expected value SHALL be the bit-reversal of invec (bit i maps to bit WIDTH-1-i), delayed LATENCY cycles.
REQ-015 The delay line SHALL shift every cycle in all states, independent of the FSM.
REQ-016 The FSM SHALL have four states: IDLE, PRIME, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 at a clock edge SHALL move the FSM to PRIME and clear err_count, sample_count and the prime counter on that same edge.
REQ-018 start SHALL be ignored in PRIME and CHECK.
REQ-019 PRIME SHALL last exactly LATENCY cycles, then move to CHECK.
REQ-020 In CHECK, each cycle SHALL compare outvec with the expected value and increment sample_count.
REQ-021 In CHECK, a mismatch SHALL increment err_count, saturating at 255.
REQ-022 On the edge where sample_count reaches NUM_SAMPLES, CHECK SHALL move to DONE.
REQ-023 Compare results SHALL appear in the counters one cycle after the compared inputs.
REQ-024 DONE SHALL hold done, pass and both counts stable until start or reset.
REQ-025 A comparison SHALL be mismatching if any bit differs; X/Z is not handled.

Reset
REQ-026 While reset=1 at a clock edge, the FSM SHALL go to IDLE, the delay line SHALL clear to 0, and the counters SHALL clear to 0.
REQ-027 After reset, busy, done and pass SHALL be 0, and err_count and sample_count SHALL be 0.
REQ-028 Reset SHALL take priority over start.
REQ-029 Reset asserted during PRIME or CHECK SHALL abort the run with no DONE.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (2 bits) and the count width constant (8).
REQ-031 The delay line SHALL be one sub-module, vec_delay, parameterised by WIDTH and LATENCY, with synchronous reset.
REQ-032 The bit reversal SHALL be combinational on the delay-line input, so vec_delay stores reversed data.

Verification
REQ-033 Reset scenario: reset for 2 cycles with default parameters -> busy=0, done=0, pass=0, err_count=0 and sample_count=0 on the next cycle.
REQ-034 Correct-swap scenario: a correct swap stage (invec 0,1,2,3 repeating), then start pulse -> busy=1 for 1+4 cycles, then done=1, pass=1, sample_count=4, err_count=0.
REQ-035 Faulty-stage scenario: a pass-through (no swap) stage with invec counting 0,1,2,3 -> done=1, pass=0, err_count=2 (values 1 and 2 differ).
REQ-036 Start-in-run scenario: start held high for the whole run -> the second start is ignored until DONE, then a new run begins with counts cleared.
REQ-037 Reset-mid-run scenario: reset asserted in CHECK after 2 samples -> IDLE, counts 0, done never asserts.
REQ-038 Saturation scenario: WIDTH=4, NUM_SAMPLES=255, an always-wrong stage -> err_count=255 and sample_count=255, with no wrap.
